// File: rtl/column_serialize_pkg.sv
// Shared types and helpers for the column_serialize block.
//   bank_state_e : life cycle of one ping-pong bank
//                  (EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY).
//   clog2_min1   : ceil(log2(value)), never less than 1, used to size
//                  address and lane-select fields.
package column_serialize_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/column_serialize_if.sv
// Valid/ready stream bundle used on both sides of column_serialize.
//   data : payload (W bits)
//   val  : payload valid, driven by the master
//   rdy  : sink can take the payload, driven by the slave
// A beat transfers on a rising edge where val & rdy.
interface column_serialize_if #(
  parameter int W = 8
) ();
  logic [W-1:0] data;
  logic         val;
  logic         rdy;

  modport master (output data, output val, input rdy);
  modport slave  (input data, input val, output rdy);
endinterface

// File: rtl/column_serialize_line_mem.sv
// line_mem: simple dual-port line memory.
//   clk   : write and read clock
//   we    : write enable; wdata is stored at waddr
//   re    : read enable; mem[raddr] appears on rdata after the edge
//   rdata : registered read data (one cycle latency), holds when re is low
module line_mem
  import column_serialize_pkg::*;
#(
  parameter  int IMG_WIDTH = 8,
  parameter  int MEM_DEPTH = 15,
  localparam int AW        = clog2_min1(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [IMG_WIDTH-1:0] wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [IMG_WIDTH-1:0] rdata
);

  logic [IMG_WIDTH-1:0] mem [MEM_DEPTH];

  // NOTE: the storage array has no reset; every location is written before it
  // is read, and leaving it unreset lets synthesis map it onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/column_serialize.sv
// column_serialize: turns a stream of HEIGHT_NB-pixel columns back into a
// raster pixel stream, one group of HEIGHT_NB lines at a time, oldest line
// (lane HEIGHT_NB-1) first. Two ping-pong banks let one group fill while the
// other drains.
//   clk, rst  : clock, synchronous active-high reset
//   cfg_width : line length in pixels, taken when cfg_set is high
//   cfg_set   : load cfg_width (if 1..MEM_DEPTH) and abort everything in flight
//   up        : column input stream (IMG_WIDTH*HEIGHT_NB bits per beat)
//   dn        : raster pixel output stream (IMG_WIDTH bits per beat)
module column_serialize
  import column_serialize_pkg::*;
#(
  parameter int HEIGHT_NB  = 3,
  parameter int IMG_WIDTH  = 8,
  parameter int MEM_AWIDTH = 8,
  parameter int MEM_DEPTH  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_AWIDTH-1:0] cfg_width,
  input  logic                  cfg_set,
  column_serialize_if.slave     up,
  column_serialize_if.master    dn
);

  localparam int LM_AW = clog2_min1(MEM_DEPTH);
  localparam int LW    = clog2_min1(HEIGHT_NB);
  localparam logic [MEM_AWIDTH-1:0] DEPTH_W  = MEM_AWIDTH'(MEM_DEPTH);
  localparam logic [MEM_AWIDTH-1:0] ONE_W    = MEM_AWIDTH'(1);
  localparam logic [LW-1:0]         TOP_LANE = LW'(HEIGHT_NB - 1);

  // Control state (registered) and its next-state values.
  logic [MEM_AWIDTH-1:0] width_q, width_d;
  bank_state_e           bank_q [2];
  bank_state_e           bank_d [2];
  logic                  wb_q, wb_d;
  logic                  rb_q, rb_d;
  logic [MEM_AWIDTH-1:0] wcnt_q, wcnt_d;
  logic [MEM_AWIDTH-1:0] rc_q, rc_d;
  logic [LW-1:0]         rl_q, rl_d;
  // One read may be in flight; remember which RAM it came from.
  logic                  inflight_q, inflight_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [LW-1:0]         rd_lane_q, rd_lane_d;
  // Two-entry output skid FIFO.
  logic [IMG_WIDTH-1:0]  fifo_q [2];
  logic [IMG_WIDTH-1:0]  fifo_d [2];
  logic                  fifo_wp_q, fifo_wp_d;
  logic                  fifo_rp_q, fifo_rp_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;

  logic                  accept;
  logic                  issue;
  logic                  pop;
  logic                  room;
  logic [1:0]            occ_after_pop;
  logic [MEM_AWIDTH-1:0] last_col;
  logic [IMG_WIDTH-1:0]  rd_word;
  logic [IMG_WIDTH-1:0]  rdata_w [2][HEIGHT_NB];

  assign up.rdy  = !rst && (bank_q[wb_q] == BANK_EMPTY || bank_q[wb_q] == BANK_FILLING);
  assign dn.val  = (fifo_cnt_q != 2'd0);
  assign dn.data = fifo_q[fifo_rp_q];

  assign last_col = width_q - ONE_W;
  assign accept   = up.val && up.rdy && !cfg_set;
  assign pop      = dn.val && dn.rdy;
  // Count the slot freed by this cycle's pop, otherwise a steady stream would
  // stall every other cycle waiting for the FIFO to report space.
  assign occ_after_pop = fifo_cnt_q - 2'(pop);
  assign room          = (occ_after_pop + 2'(inflight_q)) < 2'd2;
  assign issue         = !cfg_set && room &&
                         (bank_q[rb_q] == BANK_FULL || bank_q[rb_q] == BANK_DRAINING);

  // 2 banks x HEIGHT_NB line memories; lane k of a column goes to RAM k.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar k = 0; k < HEIGHT_NB; k++) begin : g_lane
      line_mem #(
        .IMG_WIDTH (IMG_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
      ) u_line_mem (
        .clk   (clk),
        .we    (accept && (wb_q == 1'(b))),
        .waddr (wcnt_q[LM_AW-1:0]),
        .wdata (up.data[k*IMG_WIDTH +: IMG_WIDTH]),
        .re    (issue && (rb_q == 1'(b)) && (rl_q == LW'(k))),
        .raddr (rc_q[LM_AW-1:0]),
        .rdata (rdata_w[b][k])
      );
    end
  end

  always_comb begin
    rd_word = rdata_w[rd_bank_q][rd_lane_q];
  end

  // NOTE: every variable gets its current value first so that no path through
  // this block leaves one unassigned, which would infer a latch.
  always_comb begin
    width_d    = width_q;
    bank_d     = bank_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    wcnt_d     = wcnt_q;
    rc_d       = rc_q;
    rl_d       = rl_q;
    inflight_d = 1'b0;
    rd_bank_d  = rd_bank_q;
    rd_lane_d  = rd_lane_q;
    fifo_d     = fifo_q;
    fifo_wp_d  = fifo_wp_q;
    fifo_rp_d  = fifo_rp_q;
    fifo_cnt_d = fifo_cnt_q;

    if (cfg_set) begin
      // Abort: out-of-range widths still flush, they just keep the old width.
      if (cfg_width != '0 && int'(cfg_width) <= MEM_DEPTH) width_d = cfg_width;
      bank_d[0]  = BANK_EMPTY;
      bank_d[1]  = BANK_EMPTY;
      wb_d       = 1'b0;
      rb_d       = 1'b0;
      wcnt_d     = '0;
      rc_d       = '0;
      rl_d       = TOP_LANE;
      fifo_wp_d  = 1'b0;
      fifo_rp_d  = 1'b0;
      fifo_cnt_d = 2'd0;
    end else begin
      // Write side. wb and rb never point at the same bank while both act.
      if (accept) begin
        if (wcnt_q == last_col) begin
          bank_d[wb_q] = BANK_FULL;
          wcnt_d       = '0;
          wb_d         = !wb_q;
        end else begin
          bank_d[wb_q] = BANK_FILLING;
          wcnt_d       = wcnt_q + ONE_W;
        end
      end

      // Read side: row-major, top lane first, column 0 upward.
      if (issue) begin
        inflight_d = 1'b1;
        rd_bank_d  = rb_q;
        rd_lane_d  = rl_q;
        if (rc_q == last_col) begin
          rc_d = '0;
          if (rl_q == '0) begin
            bank_d[rb_q] = BANK_EMPTY;
            rb_d         = !rb_q;
            rl_d         = TOP_LANE;
          end else begin
            bank_d[rb_q] = BANK_DRAINING;
            rl_d         = rl_q - LW'(1);
          end
        end else begin
          bank_d[rb_q] = BANK_DRAINING;
          rc_d         = rc_q + ONE_W;
        end
      end

      // Data read last cycle is now on the RAM output; capture it.
      if (inflight_q) begin
        fifo_d[fifo_wp_q] = rd_word;
        fifo_wp_d         = !fifo_wp_q;
      end
      if (pop) fifo_rp_d = !fifo_rp_q;
      fifo_cnt_d = fifo_cnt_q + 2'(inflight_q) - 2'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q    <= DEPTH_W;
      bank_q[0]  <= BANK_EMPTY;
      bank_q[1]  <= BANK_EMPTY;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      wcnt_q     <= '0;
      rc_q       <= '0;
      rl_q       <= TOP_LANE;
      inflight_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_lane_q  <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      width_q    <= width_d;
      bank_q     <= bank_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      wcnt_q     <= wcnt_d;
      rc_q       <= rc_d;
      rl_q       <= rl_d;
      inflight_q <= inflight_d;
      rd_bank_q  <= rd_bank_d;
      rd_lane_q  <= rd_lane_d;
      fifo_q     <= fifo_d;
      fifo_wp_q  <= fifo_wp_d;
      fifo_rp_q  <= fifo_rp_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule
